// File: rtl/branch_predictor.sv
// Fetch-stage BTB with 2-bit saturating direction counters, trained from decode resolution.
// Define BP_STATS_EN to add branch and mispredict event counters.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcF,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic        br_takenD,
  input  logic [31:0] targetD,
  output logic        predict_takenF,
  output logic [31:0] predict_targetF,
  output logic        mispredictD,
  output logic [31:0] redirect_pcD
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branchesD,
  output logic [31:0] stat_mispredD
`endif
);

  localparam int TAG_BITS = 32 - IDX_BITS - 2;

  logic                tbl_valid  [ENTRIES];
  logic [TAG_BITS-1:0] tbl_tag    [ENTRIES];
  logic [31:0]         tbl_target [ENTRIES];
  logic [1:0]          tbl_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] idx_f;
  logic [IDX_BITS-1:0] idx_d;
  logic [TAG_BITS-1:0] tag_f;
  logic [TAG_BITS-1:0] tag_d;
  logic                hit_f;
  logic                hit_d;
  logic                predD;
  logic [31:0]         ptgtD;
  logic                actual_d;
  logic                train;
  logic [1:0]          ctr_next;
  logic                unused_stall_pc;

  // Word-aligned PCs: the low two bits and the fetch stall play no part in prediction.
  assign unused_stall_pc = &{1'b0, stallF, pcF[1:0]};

  assign idx_f = pcF[IDX_BITS+1:2];
  assign tag_f = pcF[31:IDX_BITS+2];
  assign idx_d = pcD[IDX_BITS+1:2];
  assign tag_d = pcD[31:IDX_BITS+2];

  assign hit_f = tbl_valid[idx_f] && (tbl_tag[idx_f] == tag_f);
  assign hit_d = tbl_valid[idx_d] && (tbl_tag[idx_d] == tag_d);

  assign predict_takenF  = hit_f & tbl_ctr[idx_f][1];
  assign predict_targetF = hit_f ? tbl_target[idx_f] : 32'd0;

  // Prediction carried alongside the instruction into decode; flush beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predD <= 1'b0;
      ptgtD <= 32'd0;
    end else if (flushD) begin
      predD <= 1'b0;
      ptgtD <= 32'd0;
    end else if (!stallD) begin
      predD <= predict_takenF;
      ptgtD <= predict_targetF;
    end
  end

  assign actual_d     = branchD & br_takenD;
  assign train        = branchD & ~stallD;
  assign mispredictD  = ~stallD & ((predD != actual_d) |
                                   (predD & actual_d & (ptgtD != targetD)));
  assign redirect_pcD = actual_d ? targetD : (pcD + 32'd4);

  always_comb begin
    ctr_next = tbl_ctr[idx_d];
    if (br_takenD && (ctr_next != 2'b11)) begin
      ctr_next = ctr_next + 2'd1;
    end else if (!br_takenD && (ctr_next != 2'b00)) begin
      ctr_next = ctr_next - 2'd1;
    end
  end

  // Table write uses the pre-update entry looked up at pcD; fetch sees the change next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= 32'd0;
        tbl_ctr[i]    <= 2'b01;
      end
    end else if (train) begin
      if (hit_d) begin
        tbl_ctr[idx_d] <= ctr_next;
        if (br_takenD) begin
          tbl_target[idx_d] <= targetD;
        end
      end else if (br_takenD) begin
        tbl_valid[idx_d]  <= 1'b1;
        tbl_tag[idx_d]    <= tag_d;
        tbl_target[idx_d] <= targetD;
        tbl_ctr[idx_d]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branchesD <= 32'd0;
      stat_mispredD  <= 32'd0;
    end else begin
      if (train) begin
        stat_branchesD <= stat_branchesD + 32'd1;
      end
      if (mispredictD) begin
        stat_mispredD <= stat_mispredD + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised bench for branch_predictor against a table-level behavioural model,
// plus directed literal checks for cold miss, saturation, target change, conflict, stall/flush and reset.
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] pcF;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic [31:0] pcD;
  logic        branchD;
  logic        br_takenD;
  logic [31:0] targetD;
  logic        predict_takenF;
  logic [31:0] predict_targetF;
  logic        mispredictD;
  logic [31:0] redirect_pcD;
`ifdef BP_STATS_EN
  logic [31:0] stat_branchesD;
  logic [31:0] stat_mispredD;
`endif

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pcF(pcF),
    .stallF(stallF),
    .stallD(stallD),
    .flushD(flushD),
    .pcD(pcD),
    .branchD(branchD),
    .br_takenD(br_takenD),
    .targetD(targetD),
    .predict_takenF(predict_takenF),
    .predict_targetF(predict_targetF),
    .mispredictD(mispredictD),
    .redirect_pcD(redirect_pcD)
`ifdef BP_STATS_EN
    ,
    .stat_branchesD(stat_branchesD),
    .stat_mispredD(stat_mispredD)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one record per table slot, counters as plain integers 0..3.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  bit          m_pred;
  logic [31:0] m_ptgt;
  logic [31:0] m_branches;
  logic [31:0] m_mispred;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit exp_taken_f();
    return model_hit(pcF) && (m_ctr[slot_of(pcF)] >= 2);
  endfunction

  function automatic logic [31:0] exp_target_f();
    return model_hit(pcF) ? m_target[slot_of(pcF)] : 32'd0;
  endfunction

  function automatic bit exp_mispredict();
    bit actual;
    actual = branchD && br_takenD;
    if (stallD) return 1'b0;
    if (m_pred != actual) return 1'b1;
    return m_pred && actual && (m_ptgt != targetD);
  endfunction

  function automatic logic [31:0] exp_redirect();
    return (branchD && br_takenD) ? targetD : pcD + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 32'd0;
      m_target[i] = 32'd0;
      m_ctr[i]    = 1;
    end
    m_pred     = 1'b0;
    m_ptgt     = 32'd0;
    m_branches = 32'd0;
    m_mispred  = 32'd0;
  endtask

  // Advance the model by one rising edge using the values present before the edge.
  task automatic model_clock();
    bit          look_taken;
    logic [31:0] look_tgt;
    bit          mis;
    int          s;
    if (!rst_n) return;
    look_taken = exp_taken_f();
    look_tgt   = exp_target_f();
    mis        = exp_mispredict();
    if (branchD && !stallD) begin
      s = slot_of(pcD);
      m_branches = m_branches + 32'd1;
      if (model_hit(pcD)) begin
        if (br_takenD) begin
          m_ctr[s]    = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_target[s] = targetD;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (br_takenD) begin
        m_valid[s]  = 1'b1;
        m_tag[s]    = tag_of(pcD);
        m_target[s] = targetD;
        m_ctr[s]    = 2;
      end
    end
    if (mis) m_mispred = m_mispred + 32'd1;
    if (flushD) begin
      m_pred = 1'b0;
      m_ptgt = 32'd0;
    end else if (!stallD) begin
      m_pred = look_taken;
      m_ptgt = look_tgt;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] pc_f, input logic [31:0] pc_d,
                                input logic branch, input logic taken,
                                input logic [31:0] target, input logic stall_d,
                                input logic flush_d);
    pcF       = pc_f;
    pcD       = pc_d;
    branchD   = branch;
    br_takenD = taken;
    targetD   = target;
    stallD    = stall_d;
    flushD    = flush_d;
    stallF    = stall_d;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    check_output("predict_takenF", {31'd0, predict_takenF}, {31'd0, exp_taken_f()});
    check_output("predict_targetF", predict_targetF, exp_target_f());
    check_output("mispredictD", {31'd0, mispredictD}, {31'd0, exp_mispredict()});
    check_output("redirect_pcD", redirect_pcD, exp_redirect());
`ifdef BP_STATS_EN
    check_output("stat_branchesD", stat_branchesD, m_branches);
    check_output("stat_mispredD", stat_mispredD, m_mispred);
`endif
  end

  logic [31:0] pc_pool [8];
  logic [31:0] tgt_pool [4];

  initial begin
    pc_pool[0] = 32'h100;  pc_pool[1] = 32'h140;  pc_pool[2] = 32'h104;  pc_pool[3] = 32'h180;
    pc_pool[4] = 32'h1100; pc_pool[5] = 32'h1140; pc_pool[6] = 32'h200;  pc_pool[7] = 32'h10C;
    tgt_pool[0] = 32'h80;  tgt_pool[1] = 32'h200; tgt_pool[2] = 32'h300; tgt_pool[3] = 32'h400;

    rst_n = 1'b0;
    apply_stimulus(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Cold miss then allocation
    apply_stimulus(32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("cold_miss_taken", {31'd0, predict_takenF}, 32'd0);
    step();
    apply_stimulus(32'h100, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
    #2; check_output("cold_mispredict", {31'd0, mispredictD}, 32'd1);
    check_output("cold_redirect", redirect_pcD, 32'h80);
    step();
    apply_stimulus(32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("alloc_taken", {31'd0, predict_takenF}, 32'd1);
    check_output("alloc_target", predict_targetF, 32'h80);
    step();

    // Saturation and hysteresis
    repeat (3) begin
      apply_stimulus(32'h100, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
      #2; check_output("sat_no_mispredict", {31'd0, mispredictD}, 32'd0);
      step();
    end
    apply_stimulus(32'h100, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("nt1_mispredict", {31'd0, mispredictD}, 32'd1);
    check_output("nt1_redirect", redirect_pcD, 32'h104);
    step();
    apply_stimulus(32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("weak_taken_still", {31'd0, predict_takenF}, 32'd1);
    step();
    apply_stimulus(32'h100, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("nt2_mispredict", {31'd0, mispredictD}, 32'd1);
    step();
    apply_stimulus(32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("weak_nt_predict", {31'd0, predict_takenF}, 32'd0);
    step();

    // Target change
    apply_stimulus(32'h100, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
    step();
    apply_stimulus(32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    apply_stimulus(32'h100, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    #2; check_output("tgt_mispredict", {31'd0, mispredictD}, 32'd1);
    check_output("tgt_redirect", redirect_pcD, 32'h200);
    step();
    apply_stimulus(32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("tgt_updated", predict_targetF, 32'h200);
    step();

    // Conflict eviction at the same slot
    apply_stimulus(32'h140, 32'h140, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
    step();
    apply_stimulus(32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("evicted_miss", {31'd0, predict_takenF}, 32'd0);
    apply_stimulus(32'h140, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1; check_output("evictor_hit", predict_targetF, 32'h300);
    step();

    // Stalled resolve neither redirects nor trains
    repeat (3) begin
      apply_stimulus(32'h140, 32'h140, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      #2; check_output("stall_no_mispredict", {31'd0, mispredictD}, 32'd0);
      step();
    end
    apply_stimulus(32'h140, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("stall_no_train", {31'd0, predict_takenF}, 32'd1);
    step();

    // Flush wins over stall
    apply_stimulus(32'h140, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    apply_stimulus(32'h140, 32'h140, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #2; check_output("flush_over_stall", {31'd0, mispredictD}, 32'd0);
    step();

    // Asynchronous reset during a stall
    apply_stimulus(32'h140, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1; rst_n = 1'b0; model_reset();
    #1; check_output("rst_taken", {31'd0, predict_takenF}, 32'd0);
    check_output("rst_target", predict_targetF, 32'h0);
    check_output("rst_mispredict", {31'd0, mispredictD}, 32'd0);
    @(negedge clk); #1; rst_n = 1'b1;
    apply_stimulus(32'h140, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1; check_output("rst_invalidated", {31'd0, predict_takenF}, 32'd0);
    step();

    // Randomised traffic over a small PC pool so hits, conflicts and retraining all recur
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 4) == 0) ? ($urandom() & 32'hFFFF_FFFC) : tgt_pool[$urandom_range(0, 3)];
      apply_stimulus(pc_pool[$urandom_range(0, 7)], pc_pool[$urandom_range(0, 7)],
                     $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, tgt,
                     $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0);
      stallF = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) begin
        #2; rst_n = 1'b0; model_reset();
        #4; rst_n = 1'b1;
      end
      step();
    end

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
